// File: rtl/core_data_mem_bridge.sv
// Core data-port to req/ack bus bridge; stalls the core until the bus acks.
// Optional DMEM_TIMEOUT_EN aborts a BUSY phase after TIMEOUT_CYCLES.
module core_data_mem_bridge #(
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int TRANSFER_WIDTH = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic [TRANSFER_WIDTH-1:0] transfer_i,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      stall_o,
   output logic                      err_o,
   output logic                      bus_req_o,
   output logic                      bus_we_o,
   output logic [MEM_ADDR_WIDTH-1:0] bus_addr_o,
   output logic [DATA_WIDTH-1:0]     bus_wdata_o,
   output logic [TRANSFER_WIDTH-1:0] bus_be_o,
   input  logic                      bus_ack_i,
   input  logic [DATA_WIDTH-1:0]     bus_rdata_i
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   start;
   logic   ack_hit;
   logic   expire;

   assign start   = (state_q == IDLE) & req_i;
   assign ack_hit = (state_q == BUSY) & bus_ack_i;

`ifdef DMEM_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic          err_q;

   // An ack in the expiry cycle wins over the abort.
   assign expire = (state_q == BUSY) & ~bus_ack_i & (cnt_q == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (start)
            cnt_q <= '0;
         else if ((state_q == BUSY) && !bus_ack_i)
            cnt_q <= cnt_q + 1'b1;
         if (expire)
            err_q <= 1'b1;
         else if (state_q == DONE)
            err_q <= 1'b0;
      end
   end

   assign err_o = err_q;
`else
   assign expire = 1'b0;
   assign err_o  = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (req_i) state_d = BUSY;
         BUSY: if (ack_hit || expire) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_be_o    <= '0;
         rdata_o     <= '0;
      end else begin
         if (start) begin
            bus_we_o    <= we_i;
            bus_addr_o  <= addr_i;
            bus_wdata_o <= wdata_i;
            bus_be_o    <= we_i ? transfer_i : '1;
         end
         if (ack_hit && !bus_we_o)
            rdata_o <= bus_rdata_i;
         else if (expire)
            rdata_o <= '0;
      end
   end

   assign bus_req_o = (state_q == BUSY);
   assign stall_o   = start | (state_q == BUSY);

endmodule

// File: tb/tb_core_data_mem_bridge.sv
// Randomized bench for core_data_mem_bridge against a transaction-timeline model.
module tb_core_data_mem_bridge;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = 4;
`ifdef DMEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic          clk;
   logic          rst;
   logic          req_i;
   logic          we_i;
   logic [AW-1:0] addr_i;
   logic [DW-1:0] wdata_i;
   logic [BW-1:0] transfer_i;
   logic [DW-1:0] rdata_o;
   logic          stall_o;
   logic          err_o;
   logic          bus_req_o;
   logic          bus_we_o;
   logic [AW-1:0] bus_addr_o;
   logic [DW-1:0] bus_wdata_o;
   logic [BW-1:0] bus_be_o;
   logic          bus_ack_i;
   logic [DW-1:0] bus_rdata_i;

   core_data_mem_bridge #(
      .MEM_ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TRANSFER_WIDTH(BW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_i(req_i),
      .we_i(we_i),
      .addr_i(addr_i),
      .wdata_i(wdata_i),
      .transfer_i(transfer_i),
      .rdata_o(rdata_o),
      .stall_o(stall_o),
      .err_o(err_o),
      .bus_req_o(bus_req_o),
      .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o),
      .bus_be_o(bus_be_o),
      .bus_ack_i(bus_ack_i),
      .bus_rdata_i(bus_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;
   int stall_cnt;
   bit chk_en;

   // Model: last latched bus request, last load data, per-cycle flags
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [BW-1:0] m_be;
   logic [DW-1:0] m_rdata;
   logic          e_stall;
   logic          e_req;
   logic          e_err;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (stall_o === 1'b1) stall_cnt++;
         check("stall", 64'(stall_o), 64'(e_stall));
         check("bus_req", 64'(bus_req_o), 64'(e_req));
         check("err", 64'(err_o), 64'(e_err));
         check("bus_we", 64'(bus_we_o), 64'(m_we));
         check("bus_addr", 64'(bus_addr_o), 64'(m_addr));
         check("bus_wdata", 64'(bus_wdata_o), 64'(m_wdata));
         check("bus_be", 64'(bus_be_o), 64'(m_be));
         check("rdata", 64'(rdata_o), 64'(m_rdata));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_be    = '0;
      m_rdata = '0;
   endtask

   task automatic noise();
      bus_ack_i   = 1'($urandom);
      bus_rdata_i = $urandom;
   endtask

   task automatic idle_cycle();
      req_i      = 1'b0;
      we_i       = 1'($urandom);
      addr_i     = AW'($urandom);
      wdata_i    = $urandom;
      transfer_i = BW'($urandom);
      noise();
      e_stall = 1'b0;
      e_req   = 1'b0;
      e_err   = 1'b0;
      step();
   endtask

   task automatic req_cycle(input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd,
                            input logic [BW-1:0] be);
      req_i      = 1'b1;
      we_i       = we;
      addr_i     = a;
      wdata_i    = wd;
      transfer_i = be;
      noise();
      e_stall = 1'b1;
      e_req   = 1'b0;
      e_err   = 1'b0;
      step();
      m_we    = we;
      m_addr  = a;
      m_wdata = wd;
      m_be    = we ? be : '1;
   endtask

   task automatic done_cycle(input bit err);
      req_i      = 1'($urandom);
      we_i       = 1'($urandom);
      addr_i     = AW'($urandom);
      wdata_i    = $urandom;
      transfer_i = BW'($urandom);
      noise();
      e_stall = 1'b0;
      e_req   = 1'b0;
      e_err   = err;
      step();
   endtask

   // Request, w wait cycles, ack, one commit cycle
   task automatic txn(input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [BW-1:0] be,
                      input int w, input logic [DW-1:0] rd);
      req_cycle(we, a, wd, be);
      for (int i = 0; i <= w; i++) begin
         bus_ack_i   = (i == w);
         bus_rdata_i = (i == w) ? rd : $urandom;
         e_stall     = 1'b1;
         e_req       = 1'b1;
         step();
      end
      if (!we) m_rdata = rd;
      done_cycle(1'b0);
   endtask

   task automatic timeout_txn(input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd,
                              input logic [BW-1:0] be);
      req_cycle(we, a, wd, be);
      for (int i = 0; i < TO; i++) begin
         bus_ack_i   = 1'b0;
         bus_rdata_i = $urandom;
         e_stall     = 1'b1;
         e_req       = 1'b1;
         step();
      end
      m_rdata = '0;
      done_cycle(1'b1);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      stall_cnt  = 0;
      chk_en     = 1'b0;
      rst        = 1'b1;
      req_i      = 1'b1;
      we_i       = 1'b0;
      addr_i     = 10'h010;
      wdata_i    = '0;
      transfer_i = '0;
      bus_ack_i  = 1'b0;
      bus_rdata_i = '0;
      model_clear();
      e_stall = 1'b0;
      e_req   = 1'b0;
      e_err   = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_bus_req", 64'(bus_req_o), 64'd0);
      check("rst_rdata", 64'(rdata_o), 64'd0);
      check("rst_stall", 64'(stall_o), 64'd1);
      check("rst_bus_be", 64'(bus_be_o), 64'd0);

      @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;

      stall_cnt = 0;
      txn(1'b0, 10'h010, 32'h0, 4'h0, 0, 32'hCAFEF00D);
      check("load_stall_cycles", 64'(stall_cnt), 64'd2);
      check("load_rdata", 64'(rdata_o), 64'hCAFEF00D);
      check("load_be", 64'(bus_be_o), 64'hF);
      check("load_addr", 64'(bus_addr_o), 64'h010);

      stall_cnt = 0;
      txn(1'b1, 10'h020, 32'h12345678, 4'b0011, 3, 32'hDEADBEEF);
      check("store_stall_cycles", 64'(stall_cnt), 64'd5);
      check("store_we", 64'(bus_we_o), 64'd1);
      check("store_be", 64'(bus_be_o), 64'h3);
      check("store_wdata", 64'(bus_wdata_o), 64'h12345678);
      check("store_rdata_kept", 64'(rdata_o), 64'hCAFEF00D);

      txn(1'b0, 10'h3FC, 32'h0, 4'h0, 1, 32'h0BADC0DE);
      txn(1'b1, 10'h001, 32'hA5A5A5A5, 4'b1000, 0, 32'h11111111);
      check("b2b_rdata", 64'(rdata_o), 64'h0BADC0DE);

      req_cycle(1'b0, 10'h155, 32'h0, 4'h0);
      bus_ack_i = 1'b0;
      e_stall   = 1'b1;
      e_req     = 1'b1;
      step();
      rst   = 1'b1;
      req_i = 1'b0;
      model_clear();
      e_stall = 1'b0;
      e_req   = 1'b0;
      #1;
      check("midrst_req_drop", 64'(bus_req_o), 64'd0);
      check("midrst_rdata", 64'(rdata_o), 64'd0);
      step();
      rst = 1'b0;
      txn(1'b0, 10'h2AA, 32'h0, 4'h0, 2, 32'h600DF00D);

      for (int n = 0; n < 80; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) idle_cycle();
`ifdef DMEM_TIMEOUT_EN
         if ($urandom_range(0, 5) == 0)
            timeout_txn(1'($urandom), AW'($urandom), $urandom, BW'($urandom));
         else
            txn(1'($urandom), AW'($urandom), $urandom, BW'($urandom),
                $urandom_range(0, TO - 1), $urandom);
`else
         txn(1'($urandom), AW'($urandom), $urandom, BW'($urandom),
             $urandom_range(0, 4), $urandom);
`endif
      end

`ifdef DMEM_TIMEOUT_EN
      timeout_txn(1'b0, 10'h0F0, 32'h0, 4'h0);
      check("timeout_rdata", 64'(rdata_o), 64'd0);
`endif

      idle_cycle();
      idle_cycle();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
